// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed 7-segment scan controller.
//   SUBPHASES       - number of brightness sub-phases per digit slot
//   HEX_GLYPHS      - segment patterns (bit0 = a .. bit6 = g) for hex 0..F
//   digit_reg_t     - per-digit storage: mode (1 = hex), dot, 7 data bits
//   digit_segments  - active-high segment pattern for a stored digit
//   digit_is_blank  - true for a raw all-off digit with no dot
package seg7_pkg;

  localparam int SUBPHASES = 16;

  // Index 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic       mode;
    logic       dot;
    logic [6:0] data;
  } digit_reg_t;

  function automatic logic [6:0] digit_segments(input digit_reg_t d);
    return d.mode ? HEX_GLYPHS[d.data[3:0]] : d.data;
  endfunction

  // Hex-mode zero still shows a glyph, so only raw mode can be blank.
  function automatic logic digit_is_blank(input digit_reg_t d);
    return !d.mode && !d.dot && (d.data == 7'h00);
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// seg7_tick_gen: divides clk into digit slots of SLOT cycles, each split
// into SUBPHASES sub-phases of SLOT/SUBPHASES cycles.
//   clk, rst  - clock; asynchronous active-low reset
//   slot_end  - one-cycle pulse on the last cycle of every slot
//   sub_end   - one-cycle pulse on the last cycle of sub-phases 0..14;
//               sub-phase 15 ends with slot_end and absorbs the remainder
module seg7_tick_gen
  import seg7_pkg::*;
#(
  parameter int SLOT = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic sub_end
);

  localparam int SUB_LEN = SLOT / SUBPHASES;
  localparam int CW      = $clog2(SLOT);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [CW-1:0] sub_cnt_q, sub_cnt_d;

  always_comb begin
    slot_end = (slot_cnt_q == CW'(SLOT - 1));
    // Past the first fifteen sub-phases no more sub-phase ends are issued.
    sub_end  = (sub_cnt_q == CW'(SUB_LEN - 1)) &&
               (slot_cnt_q < CW'((SUBPHASES - 1) * SUB_LEN));
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + CW'(1);
    sub_cnt_d  = (slot_end || sub_end) ? '0 : sub_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q <= '0;
      sub_cnt_q  <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for NUM_DIGITS 7-segment digits
// with a writable digit register file and 16-level PWM brightness.
//   clk, rst     - clock; asynchronous active-low reset
//   we, waddr    - write strobe and digit address (out-of-range ignored)
//   wdata, wmode - [7] dot, [6:0] raw segments or [3:0] hex nibble (wmode=1)
//   bright       - brightness 0..15, sampled at each slot start
//   blink_mask   - per-digit blink enable (only with SEG7_BLINK_EN)
//   dig_en       - digit enables, one-hot active or all inactive
//   seg, dp      - segments a..g and decimal point
//   frame_start  - one-cycle pulse as the scan enters digit 0
// Optional feature macro: SEG7_BLINK_EN adds blink_mask and the blink phase.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int FPGA_FREQ    = 50_000_000,
  parameter  int REFRESH_FREQ = 150,
  parameter  int ACTIVE_LOW   = 1,
  parameter  int BLINK_FRAMES = 64,
  localparam int AW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [7:0]            wdata,
  input  logic                  wmode,
  input  logic [3:0]            bright,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int            SLOT = FPGA_FREQ / (REFRESH_FREQ * NUM_DIGITS);
  localparam logic          POL  = (ACTIVE_LOW != 0);
  localparam logic [AW:0]   ND_W = (AW + 1)'(NUM_DIGITS);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
      $error("seg7_scan_ctrl: NUM_DIGITS must be 1..16");
    end
    if (SLOT < SUBPHASES) begin : g_bad_slot
      $error("seg7_scan_ctrl: slot shorter than 16 cycles");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("seg7_scan_ctrl: BLINK_FRAMES must be at least 1");
    end
  endgenerate

  logic slot_end, sub_end;

  seg7_tick_gen #(.SLOT(SLOT)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .slot_end (slot_end),
    .sub_end  (sub_end)
  );

  digit_reg_t            digit_q [NUM_DIGITS];
  digit_reg_t            digit_d [NUM_DIGITS];
  logic [AW-1:0]         scan_idx_q, scan_idx_d;
  logic [3:0]            phase_q, phase_d;
  logic [3:0]            bright_q, bright_d;
  logic                  slot_first_q, slot_first_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_start_q, frame_start_d;
  logic [3:0]            bright_eff;
  digit_reg_t            cur;
  logic                  lit;
  logic                  blink_off;

`ifdef SEG7_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          frame_end;

  always_comb begin
    frame_end   = slot_end && (scan_idx_q == AW'(NUM_DIGITS - 1));
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_end) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
    blink_off = !blink_on_q && blink_mask[scan_idx_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`else
  always_comb begin
    blink_off = 1'b0;
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_d[i] = digit_q[i];
    end
    if (we && ({1'b0, waddr} < ND_W)) begin
      digit_d[waddr] = '{mode: wmode, dot: wdata[7], data: wdata[6:0]};
    end

    scan_idx_d = scan_idx_q;
    if (slot_end) begin
      scan_idx_d = (scan_idx_q == AW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + AW'(1);
    end
    phase_d      = slot_end ? 4'd0 : (sub_end ? phase_q + 4'd1 : phase_q);
    slot_first_d = slot_end;

    // The slot's first cycle uses the live input so a new level applies at once.
    bright_eff = slot_first_q ? bright : bright_q;
    bright_d   = bright_eff;

    cur = digit_q[scan_idx_q];
    lit = (phase_q < bright_eff) && !digit_is_blank(cur) && !blink_off;

    dig_en_d      = (lit ? (NUM_DIGITS'(1) << scan_idx_q) : '0) ^ {NUM_DIGITS{POL}};
    seg_d         = (lit ? digit_segments(cur) : 7'h00) ^ {7{POL}};
    dp_d          = (lit & cur.dot) ^ POL;
    frame_start_d = slot_first_q && (scan_idx_q == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= '0;
      end
      scan_idx_q    <= '0;
      phase_q       <= '0;
      bright_q      <= '0;
      slot_first_q  <= 1'b1;
      dig_en_q      <= {NUM_DIGITS{POL}};
      seg_q         <= {7{POL}};
      dp_q          <= POL;
      frame_start_q <= 1'b0;
    end else begin
      digit_q       <= digit_d;
      scan_idx_q    <= scan_idx_d;
      phase_q       <= phase_d;
      bright_q      <= bright_d;
      slot_first_q  <= slot_first_d;
      dig_en_q      <= dig_en_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dig_en      = dig_en_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl with a 16-cycle
// slot and one-cycle sub-phases. A cycle model predicts every output sample
// through a scoreboard queue; a vector table and hand sequences cover
// brightness, blanking, live rewrite, mid-slot reset and (with
// SEG7_BLINK_EN) blinking.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SLOT  = 16;
  localparam int FRAME = SLOT * ND;
  localparam int BF    = 2;

  typedef struct packed {
    logic [3:0] dig_en;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  typedef struct {
    logic [1:0] addr;
    logic       mode;
    logic [7:0] wdata;
    logic [3:0] bright;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         exp_lit;
  } vec_t;

  localparam obs_t IDLE_OBS = '{dig_en: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [1:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       wmode = 1'b0;
  logic [3:0] bright = '0;
`ifdef SEG7_BLINK_EN
  logic [3:0] blink_mask = '0;
`endif
  logic [3:0] dig_en;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;
  obs_t       observed;

  assign observed = '{dig_en: dig_en, seg: seg, dp: dp, fs: frame_start};

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .FPGA_FREQ    (6400),
    .REFRESH_FREQ (100),
    .ACTIVE_LOW   (1),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .wmode       (wmode),
    .bright      (bright),
`ifdef SEG7_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .dig_en      (dig_en),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  int         n_compared = 0;
  int         n_mismatched = 0;
  obs_t       exp_q[$];
  logic [8:0] m_digit [ND];
  logic [3:0] m_bright_l = '0;
  int         m_pos = 0;
  bit         sb_on = 0;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Prediction for the sample produced by the edge taken at position s.
  function automatic obs_t modelExpect(input int s, input logic [3:0] bright_now);
    int         idx;
    int         ph;
    logic [3:0] bl;
    logic [8:0] d;
    logic [6:0] pat;
    bit         lit;
    obs_t       o;
    idx = (s / SLOT) % ND;
    ph  = s % SLOT;
    bl  = (ph == 0) ? bright_now : m_bright_l;
    d   = m_digit[idx];
    pat = d[8] ? glyph(d[3:0]) : d[6:0];
    lit = (ph < int'(bl)) && (d != 9'h000);
`ifdef SEG7_BLINK_EN
    if (((s / FRAME) / BF) % 2 == 1 && blink_mask[idx]) lit = 0;
`endif
    o = IDLE_OBS;
    if (lit) begin
      o.dig_en = ~(4'b0001 << idx);
      o.seg    = ~pat;
      o.dp     = ~d[7];
    end
    o.fs = (s % FRAME == 0);
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input bit w, input logic [1:0] a, input logic m, input logic [7:0] d);
    obs_t e;
    we    = w;
    waddr = a;
    wmode = m;
    wdata = d;
    if (sb_on) exp_q.push_back(modelExpect(m_pos, bright));
    @(posedge clk);
    if (sb_on) begin
      if (w) m_digit[a] = {m, d};
      if (m_pos % SLOT == 0) m_bright_l = bright;
      m_pos++;
    end
    #1;
    we = 1'b0;
    if (sb_on) begin
      e = exp_q.pop_front();
      checkOutput($sformatf("cycle %0d outputs", m_pos - 1), observed, e);
    end
  endtask

  task automatic idleTick();
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  task automatic doReset(input int hold);
    rst   = 1'b0;
    sb_on = 0;
    for (int i = 0; i < ND; i++) m_digit[i] = '0;
    #1;
    checkOutput("reset immediate", observed, IDLE_OBS);
    repeat (hold) begin
      @(posedge clk);
      #1;
      checkOutput("reset hold", observed, IDLE_OBS);
    end
    rst        = 1'b1;
    m_pos      = 0;
    m_bright_l = '0;
    sb_on      = 1;
  endtask

  task automatic syncFrame();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      idleTick();
      if (frame_start === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("frame sync timeout", 32'd0, 32'd1);
  endtask

  task automatic observeFrame(input logic [1:0] addr, output int lit, output int first,
                              output logic [6:0] seg_seen, output logic dp_seen);
    logic [3:0] pat;
    lit      = 0;
    first    = -1;
    seg_seen = 7'h7F;
    dp_seen  = 1'b1;
    pat      = ~(4'b0001 << addr);
    syncFrame();
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) idleTick();
      if (dig_en === pat) begin
        if (first < 0) begin
          first    = k;
          seg_seen = seg;
          dp_seen  = dp;
        end
        lit++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs [10];
    int         lit;
    int         first;
    int         gap;
    logic [6:0] sseen;
    logic       dseen;
    logic [6:0] exp_seg_pin;
    logic       exp_dp_pin;

    vecs[0] = '{2'd0, 1'b1, 8'h01, 4'd15, 7'h06, 1'b0, 15};
    vecs[1] = '{2'd1, 1'b1, 8'h02, 4'd15, 7'h5B, 1'b0, 15};
    vecs[2] = '{2'd2, 1'b1, 8'h03, 4'd15, 7'h4F, 1'b0, 15};
    vecs[3] = '{2'd3, 1'b1, 8'h04, 4'd15, 7'h66, 1'b0, 15};
    vecs[4] = '{2'd0, 1'b0, 8'hC9, 4'd4,  7'h49, 1'b1, 4};
    vecs[5] = '{2'd2, 1'b0, 8'h00, 4'd15, 7'h00, 1'b0, 0};
    vecs[6] = '{2'd3, 1'b1, 8'h8E, 4'd7,  7'h79, 1'b1, 7};
    vecs[7] = '{2'd1, 1'b1, 8'h0F, 4'd0,  7'h00, 1'b0, 0};
    vecs[8] = '{2'd1, 1'b1, 8'h0B, 4'd15, 7'h7C, 1'b0, 15};
    vecs[9] = '{2'd2, 1'b1, 8'h00, 4'd15, 7'h3F, 1'b0, 15};

    #2;
    doReset(3);
    bright = 4'd15;
    idleTick();
    checkOutput("frame_start after release", frame_start, 1'b1);

    for (int v = 0; v < 10; v++) begin
      bright = vecs[v].bright;
      applyStimulus(1'b1, vecs[v].addr, vecs[v].mode, vecs[v].wdata);
      observeFrame(vecs[v].addr, lit, first, sseen, dseen);
      checkOutput($sformatf("vec%0d lit cycles", v), lit, vecs[v].exp_lit);
      if (vecs[v].exp_lit > 0) begin
        exp_seg_pin = ~vecs[v].exp_seg;
        exp_dp_pin  = ~vecs[v].exp_dp;
        checkOutput($sformatf("vec%0d first lit offset", v), first, vecs[v].addr * SLOT);
        checkOutput($sformatf("vec%0d seg", v), sseen, exp_seg_pin);
        checkOutput($sformatf("vec%0d dp", v), dseen, exp_dp_pin);
      end
    end

    // Frame period
    syncFrame();
    gap = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      idleTick();
      if (frame_start === 1'b1) begin
        gap = i;
        break;
      end
    end
    checkOutput("frame period", gap, FRAME);

    // Rewrite digit 1 while it is on the pins
    bright = 4'd15;
    applyStimulus(1'b1, 2'd1, 1'b1, 8'h02);
    syncFrame();
    repeat (19) idleTick();
    applyStimulus(1'b1, 2'd1, 1'b1, 8'h0A);
    exp_seg_pin = ~7'h5B;
    checkOutput("live write old glyph", seg, exp_seg_pin);
    idleTick();
    exp_seg_pin = ~7'h77;
    checkOutput("live write new glyph", seg, exp_seg_pin);

    // Reset in the middle of the digit-2 slot
    syncFrame();
    repeat (36) idleTick();
    checkOutput("digit 2 lit before reset", dig_en, 4'b1011);
    doReset(2);
    idleTick();
    checkOutput("restart frame_start", frame_start, 1'b1);
    checkOutput("restart blank digits", dig_en, 4'hF);
    bright = 4'd9;
    applyStimulus(1'b1, 2'd0, 1'b0, 8'h3F);
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h80);
    applyStimulus(1'b1, 2'd3, 1'b1, 8'h07);
    repeat (2 * FRAME) idleTick();

`ifdef SEG7_BLINK_EN
    begin
      int cnt0 [6];
      int cnt1 [6];
      int s;
      for (int f = 0; f < 6; f++) begin
        cnt0[f] = 0;
        cnt1[f] = 0;
      end
      doReset(1);
      blink_mask = 4'b0001;
      bright     = 4'd15;
      applyStimulus(1'b1, 2'd0, 1'b1, 8'h08);
      applyStimulus(1'b1, 2'd1, 1'b1, 8'h09);
      while (m_pos < 6 * FRAME) begin
        idleTick();
        s = m_pos - 1;
        if (dig_en === 4'b1110) cnt0[s / FRAME]++;
        if (dig_en === 4'b1101) cnt1[s / FRAME]++;
      end
      for (int f = 1; f < 6; f++) begin
        checkOutput($sformatf("blink frame %0d digit 0", f), cnt0[f], (f == 2 || f == 3) ? 0 : 15);
        checkOutput($sformatf("blink frame %0d digit 1", f), cnt1[f], 15);
      end
      blink_mask = 4'b0000;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: digit count, legal range 1..16.
REQ-002 Parameter FPGA_FREQ, default 50_000_000: clk frequency in Hz.
REQ-003 Parameter REFRESH_FREQ, default 150: full-frame refresh rate in Hz.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = seg, dp and dig_en are active-low; 0 = active-high.
REQ-005 Parameter BLINK_FRAMES, default 64: frames per blink half-period; used only with SEG7_BLINK_EN.
REQ-006 Port clk, input, 1: clock.
REQ-007 Port rst, input, 1: reset, asynchronous, active-low.
REQ-008 Port we, input, 1: write strobe for the digit register file.
REQ-009 Port waddr, input, AW = max(1, clog2(NUM_DIGITS)): digit address; writes with waddr >= NUM_DIGITS are ignored.
REQ-010 Port wdata, input, 8: [7] = dot; [6:0] = raw segments, or [3:0] = hex nibble when wmode = 1.
REQ-011 Port wmode, input, 1: 1 = hex-decode the digit, 0 = raw segments.
REQ-012 Port bright, input, 4: brightness 0..15, sampled at each slot start.
REQ-013 Port blink_mask, input, NUM_DIGITS: per-digit blink enable; present only with SEG7_BLINK_EN.
REQ-014 Port dig_en, output, NUM_DIGITS: digit enables, one-hot active or all inactive.
REQ-015 Port seg, output, 7: segments a..g.
REQ-016 Port dp, output, 1: decimal point.
REQ-017 Port frame_start, output, 1: one-cycle pulse when the scan enters digit 0.

Function
REQ-018 Single clock domain: no derived clocks; all timing SHALL come from internal enable ticks.
REQ-019 SLOT = FPGA_FREQ / (REFRESH_FREQ * NUM_DIGITS) cycles, integer-truncated and elaborated as a constant; elaboration SHALL fail if SLOT < 16.
REQ-020 Digit register: 9 bits per digit (mode, dot, 7 data bits), written on the clk edge when we = 1; a write to the digit being displayed SHALL appear on the outputs the next cycle.
REQ-021 Scan index SHALL increment at each slot end and wrap from NUM_DIGITS-1 to 0; frame_start SHALL pulse on the first cycle of the digit-0 slot.
REQ-022 Each slot is divided into 16 sub-phases of SLOT/16 cycles each; any remainder cycles SHALL fall in sub-phase 15.
REQ-023 The current digit is lit in sub-phases p < bright_latched; bright = 0 SHALL blank the display, and bright = 15 lights 15/16 of each slot.
REQ-024 Hex decode covers 0-F in standard 7-seg glyphs from the package table; raw mode passes data[6:0] unchanged.
REQ-025 A digit with a raw pattern of 0x00 and dot = 0 SHALL keep its dig_en inactive (no ghosting).
REQ-026 dig_en, seg and dp SHALL be registered, with one cycle of latency from scan index and sub-phase to pins.
REQ-027 When a digit is unlit, seg and dp SHALL also drive the inactive level.
REQ-028 Polarity: internal logic is active-high; ACTIVE_LOW inverts dig_en, seg and dp at the output registers only.

Reset
REQ-029 While rst = 0: every digit register = 0 (blank), scan index = 0, counters = 0, bright_latched = 0.
REQ-030 While rst = 0, all outputs SHALL be inactive and frame_start = 0.
REQ-031 Reset asserted mid-slot or mid-write SHALL take effect immediately (asynchronous).
REQ-032 After release, the first slot SHALL start at digit 0 with a frame_start pulse one cycle after release.

Configuration
REQ-033 Macro SEG7_BLINK_EN defined: the blink_mask port exists, and a blink phase toggles every BLINK_FRAMES frames.
REQ-034 With SEG7_BLINK_EN, a digit whose blink_mask bit is 1 is forced unlit during the off phase; the blink phase resets to on.
REQ-035 Macro SEG7_BLINK_EN undefined: no blink_mask port and no blink logic; behaviour is otherwise identical.

Structure
REQ-036 Package seg7_pkg SHALL hold the 16-entry hex glyph constant table, the digit-register struct typedef (mode, dot, data) and the SUBPHASES = 16 constant.
REQ-037 Sub-module seg7_tick_gen (parametrised divider) SHALL produce the slot-end and sub-phase-end enable pulses.

Verification
Bench parameters: FPGA_FREQ=6400, REFRESH_FREQ=100, NUM_DIGITS=4, so SLOT = 16 cycles and one sub-phase = 1 cycle.
REQ-038 Reset, then write hex 1,2,3,4 to digits 0-3 with bright=15 -> dig_en walks 1110, 1101, 1011, 0111 every 16 cycles; digit 0 shows seg = ~0x06; frame_start repeats every 64 cycles.
REQ-039 bright=4 -> each dig_en is active for exactly 4 of its 16 cycles; bright=0 -> all outputs stay inactive.
REQ-040 Raw write 0x00 to digit 2 -> dig_en[2] never asserts, and the other digits are unaffected.
REQ-041 Write digit 1 = hex A while digit 1 is displayed -> seg = ~0x77 one cycle after the write.
REQ-042 Assert rst at cycle 5 of the digit-2 slot -> outputs go inactive immediately; after release, the scan restarts at digit 0.
REQ-043 SEG7_BLINK_EN, BLINK_FRAMES=2, blink_mask=0001 -> digit 0 is dark for frames 2-3 and lit for frames 0-1 and 4-5; other digits are always lit.
